// File: rtl/digital_pll_lock_detect.sv
// ----------------------------------------------------------------------------
// digital_pll_lock_detect
//
// Watches the 26-bit trim word produced by digital_pll_controller (same clock
// domain), reduces it to a 5-bit popcount code and, once per evaluation window,
// decides whether the loop has settled. Housekeeping / clock-mux logic uses the
// outputs to decide when it is safe to switch over to the PLL clock.
//
// Ports
//   clock         in   reference clock, shared with digital_pll_controller
//   resetb        in   asynchronous active-low reset
//   enable        in   detector enable; low forces IDLE on the next edge
//   trim[25:0]    in   trim word from the controller
//   lock_count    in   stable windows required to lock (0 behaves as 1)
//   trim_code     out  registered popcount of trim (0..26)
//   locked        out  high only in LOCKED
//   out_of_range  out  high only in RAIL
//   lost_lock     out  one-cycle pulse when LOCKED is left by a window decision
//   unlock_count  out  saturating count of lost_lock pulses
//   state         out  IDLE=0, ACQUIRE=1, LOCKED=2, RAIL=3
// ----------------------------------------------------------------------------
module digital_pll_lock_detect #(
    parameter int WINDOW = 16,
    parameter int TOL    = 1,
    parameter int RAIL_N = 2
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        enable,
    input  logic [25:0] trim,
    input  logic [3:0]  lock_count,
    output logic [4:0]  trim_code,
    output logic        locked,
    output logic        out_of_range,
    output logic        lost_lock,
    output logic [7:0]  unlock_count,
    output logic [1:0]  state
);

    localparam int WIN_W  = $clog2(WINDOW);
    localparam int RAIL_W = (RAIL_N < 1) ? 1 : $clog2(RAIL_N + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_RAIL    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          trim_code_q, trim_code_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic [3:0]          stable_cnt_q, stable_cnt_d;
    logic [RAIL_W-1:0]   rail_cnt_q, rail_cnt_d;
    logic [4:0]          ref_q, ref_d;
    logic                ref_valid_q, ref_valid_d;
    logic                lost_lock_q, lost_lock_d;
    logic [7:0]          unlock_count_q, unlock_count_d;

    logic                win_end;
    logic                rail_hit;
    logic [RAIL_W-1:0]   rail_cnt_nxt;
    logic [5:0]          delta;
    logic                in_tol;
    logic [3:0]          stable_nxt;
    logic [3:0]          lock_target;

    // Popcount of the incoming trim word; this is the code the window logic
    // judges one clock later.
    always_comb begin
        trim_code_d = 5'd0;
        for (int i = 0; i < 26; i++) begin
            trim_code_d = trim_code_d + {4'd0, trim[i]};
        end
    end

    // Window decision helpers. Everything here works on the registered code so
    // the decision at the window end sees the code latched on the prior edge.
    always_comb begin
        win_end      = (state_q != ST_IDLE) && (win_cnt_q == WIN_W'(WINDOW - 1));
        rail_hit     = (trim_code_q == 5'd0) || (trim_code_q == 5'd26);
        rail_cnt_nxt = '0;
        if (rail_hit) begin
            rail_cnt_nxt = (rail_cnt_q >= RAIL_W'(RAIL_N)) ? rail_cnt_q : rail_cnt_q + 1'b1;
        end
        delta = (trim_code_q >= ref_q) ? ({1'b0, trim_code_q} - {1'b0, ref_q})
                                       : ({1'b0, ref_q} - {1'b0, trim_code_q});
        in_tol      = (delta <= 6'(TOL));
        stable_nxt  = (stable_cnt_q == 4'd15) ? 4'd15 : stable_cnt_q + 4'd1;
        lock_target = (lock_count == 4'd0) ? 4'd1 : lock_count;
    end

    // Next-state logic. Disable wins over everything except reset; otherwise
    // the state only moves at a window end, evaluated in priority order:
    // rail detection, rail recovery, reference load, stability counting, and
    // finally the lock-loss check.
    always_comb begin
        state_d        = state_q;
        win_cnt_d      = win_cnt_q;
        stable_cnt_d   = stable_cnt_q;
        rail_cnt_d     = rail_cnt_q;
        ref_d          = ref_q;
        ref_valid_d    = ref_valid_q;
        lost_lock_d    = 1'b0;
        unlock_count_d = unlock_count_q;

        if (!enable) begin
            state_d      = ST_IDLE;
            win_cnt_d    = '0;
            stable_cnt_d = '0;
            rail_cnt_d   = '0;
            ref_d        = '0;
            ref_valid_d  = 1'b0;
        end else if (state_q == ST_IDLE) begin
            state_d     = ST_ACQUIRE;
            win_cnt_d   = '0;
            ref_valid_d = 1'b0;
        end else begin
            win_cnt_d = win_end ? '0 : win_cnt_q + 1'b1;
            if (win_end) begin
                rail_cnt_d = rail_cnt_nxt;
                if (rail_cnt_nxt >= RAIL_W'(RAIL_N)) begin
                    state_d      = ST_RAIL;
                    stable_cnt_d = '0;
                    if (state_q == ST_LOCKED) begin
                        lost_lock_d    = 1'b1;
                        unlock_count_d = (unlock_count_q == 8'hFF) ? 8'hFF : unlock_count_q + 8'd1;
                    end
                end else if (state_q == ST_RAIL) begin
                    state_d      = ST_ACQUIRE;
                    ref_d        = trim_code_q;
                    ref_valid_d  = 1'b1;
                    stable_cnt_d = '0;
                end else if (state_q == ST_ACQUIRE) begin
                    ref_d       = trim_code_q;
                    ref_valid_d = 1'b1;
                    if (ref_valid_q) begin
                        if (in_tol) begin
                            stable_cnt_d = stable_nxt;
                            if (stable_nxt >= lock_target) begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            stable_cnt_d = '0;
                        end
                    end
                end else begin
                    // LOCKED: track the code and drop out on a large step.
                    ref_d = trim_code_q;
                    if (!in_tol) begin
                        state_d        = ST_ACQUIRE;
                        stable_cnt_d   = '0;
                        lost_lock_d    = 1'b1;
                        unlock_count_d = (unlock_count_q == 8'hFF) ? 8'hFF : unlock_count_q + 8'd1;
                    end
                end
            end
        end
    end

    // State and counter registers, cleared immediately by resetb.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q        <= ST_IDLE;
            trim_code_q    <= '0;
            win_cnt_q      <= '0;
            stable_cnt_q   <= '0;
            rail_cnt_q     <= '0;
            ref_q          <= '0;
            ref_valid_q    <= 1'b0;
            lost_lock_q    <= 1'b0;
            unlock_count_q <= '0;
        end else begin
            state_q        <= state_d;
            trim_code_q    <= trim_code_d;
            win_cnt_q      <= win_cnt_d;
            stable_cnt_q   <= stable_cnt_d;
            rail_cnt_q     <= rail_cnt_d;
            ref_q          <= ref_d;
            ref_valid_q    <= ref_valid_d;
            lost_lock_q    <= lost_lock_d;
            unlock_count_q <= unlock_count_d;
        end
    end

    assign trim_code    = trim_code_q;
    assign locked       = (state_q == ST_LOCKED);
    assign out_of_range = (state_q == ST_RAIL);
    assign lost_lock    = lost_lock_q;
    assign unlock_count = unlock_count_q;
    assign state        = state_q;

endmodule

// File: tb/tb_digital_pll_lock_detect.sv
// ----------------------------------------------------------------------------
// tb_digital_pll_lock_detect
//
// Directed bench for digital_pll_lock_detect with WINDOW=16, TOL=1, RAIL_N=2.
// A behavioural model of the detector's rules runs alongside the DUT and is
// compared every cycle; literal expectations at key points pin both.
// ----------------------------------------------------------------------------
module tb_digital_pll_lock_detect;

    localparam int WINDOW = 16;
    localparam int TOL    = 1;
    localparam int RAIL_N = 2;

    localparam logic [25:0] ONES13 = 26'h0001FFF;
    localparam logic [25:0] ONES14 = 26'h0003FFF;
    localparam logic [25:0] ONES16 = 26'h000FFFF;
    localparam logic [25:0] ONES26 = 26'h3FFFFFF;

    logic        clock = 1'b0;
    logic        resetb = 1'b1;
    logic        enable = 1'b0;
    logic [25:0] trim = '0;
    logic [3:0]  lock_count = '0;
    logic [4:0]  trim_code;
    logic        locked;
    logic        out_of_range;
    logic        lost_lock;
    logic [7:0]  unlock_count;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    digital_pll_lock_detect #(
        .WINDOW (WINDOW),
        .TOL    (TOL),
        .RAIL_N (RAIL_N)
    ) dut (
        .clock        (clock),
        .resetb       (resetb),
        .enable       (enable),
        .trim         (trim),
        .lock_count   (lock_count),
        .trim_code    (trim_code),
        .locked       (locked),
        .out_of_range (out_of_range),
        .lost_lock    (lost_lock),
        .unlock_count (unlock_count),
        .state        (state)
    );

    always #5 clock = ~clock;

    // Behavioural model: plain integers, states as numbers 0..3.
    int m_state, m_code, m_win, m_stable, m_rail, m_ref, m_unlock;
    bit m_refv, m_lost;

    always @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            m_state = 0; m_code = 0; m_win = 0; m_stable = 0; m_rail = 0;
            m_ref = 0; m_refv = 0; m_lost = 0; m_unlock = 0;
        end else begin
            int  code_now;
            int  diff;
            bit  at_end;
            code_now = $countones(trim);
            at_end   = (m_state != 0) && (m_win == WINDOW - 1);
            m_lost   = 0;
            if (!enable) begin
                m_state = 0; m_win = 0; m_stable = 0; m_rail = 0; m_ref = 0; m_refv = 0;
            end else if (m_state == 0) begin
                m_state = 1; m_win = 0; m_refv = 0;
            end else begin
                m_win = at_end ? 0 : m_win + 1;
                if (at_end) begin
                    diff   = (m_code > m_ref) ? m_code - m_ref : m_ref - m_code;
                    m_rail = (m_code == 0 || m_code == 26) ? ((m_rail + 1 > RAIL_N) ? RAIL_N : m_rail + 1) : 0;
                    if (m_rail >= RAIL_N) begin
                        if (m_state == 2) begin
                            m_lost = 1;
                            m_unlock = (m_unlock < 255) ? m_unlock + 1 : 255;
                        end
                        m_state = 3; m_stable = 0;
                    end else if (m_state == 3) begin
                        m_state = 1; m_ref = m_code; m_refv = 1; m_stable = 0;
                    end else if (m_state == 1 && !m_refv) begin
                        m_ref = m_code; m_refv = 1;
                    end else if (m_state == 1) begin
                        m_stable = (diff <= TOL) ? ((m_stable < 15) ? m_stable + 1 : 15) : 0;
                        m_ref = m_code;
                        if (m_stable >= ((lock_count == 0) ? 1 : int'(lock_count))) m_state = 2;
                    end else begin
                        m_ref = m_code;
                        if (diff > TOL) begin
                            m_state = 1; m_stable = 0; m_lost = 1;
                            m_unlock = (m_unlock < 255) ? m_unlock + 1 : 255;
                        end
                    end
                end
            end
            m_code = code_now;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [25:0] t, input logic [3:0] lc);
        enable     = en;
        trim       = t;
        lock_count = lc;
    endtask

    // Disable for one edge, then enable; returns one negedge after entering ACQUIRE,
    // so every following block of WINDOW negedges ends just after a window end.
    task automatic restart(input logic [25:0] t, input logic [3:0] lc);
        applyStimulus(1'b0, t, lc);
        @(negedge clock);
        applyStimulus(1'b1, t, lc);
        @(negedge clock);
    endtask

    task automatic runWindow();
        repeat (WINDOW) @(negedge clock);
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (check_en) begin
            checkOutput("model_trim_code", int'(trim_code), m_code);
            checkOutput("model_state", int'(state), m_state);
            checkOutput("model_locked", int'(locked), int'(m_state == 2));
            checkOutput("model_out_of_range", int'(out_of_range), int'(m_state == 3));
            checkOutput("model_lost_lock", int'(lost_lock), int'(m_lost));
            checkOutput("model_unlock_count", int'(unlock_count), m_unlock);
        end
    end

    initial begin
        #1 resetb = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_locked", int'(locked), 0);
        checkOutput("reset_trim_code", int'(trim_code), 0);
        checkOutput("reset_unlock_count", int'(unlock_count), 0);
        resetb   = 1'b1;
        check_en = 1'b1;
        @(negedge clock);

        // Lock with 13 ones and lock_count=3: window 4 end, edge 64 after enable.
        $display("[TB] lock acquisition");
        restart(ONES13, 4'd3);
        checkOutput("acq_trim_code", int'(trim_code), 13);
        checkOutput("acq_state", int'(state), 1);
        repeat (63) @(negedge clock);
        checkOutput("acq_before_we4_locked", int'(locked), 0);
        @(negedge clock);
        checkOutput("acq_we4_locked", int'(locked), 1);
        checkOutput("acq_we4_state", int'(state), 2);

        // Asynchronous reset between edges while locked.
        $display("[TB] async reset mid-lock");
        #2 resetb = 1'b0;
        #1;
        checkOutput("areset_locked", int'(locked), 0);
        checkOutput("areset_state", int'(state), 0);
        checkOutput("areset_unlock_count", int'(unlock_count), 0);
        @(negedge clock);
        resetb = 1'b1;
        @(negedge clock);
        repeat (4) runWindow();
        checkOutput("relock_locked", int'(locked), 1);

        // Step to 16 ones: delta 3 unlocks at the next window end.
        $display("[TB] step unlock");
        trim = ONES16;
        repeat (WINDOW - 1) @(negedge clock);
        checkOutput("step_pre_locked", int'(locked), 1);
        checkOutput("step_pre_lost_lock", int'(lost_lock), 0);
        @(negedge clock);
        checkOutput("step_lost_lock", int'(lost_lock), 1);
        checkOutput("step_locked", int'(locked), 0);
        checkOutput("step_state", int'(state), 1);
        checkOutput("step_unlock_count", int'(unlock_count), 1);
        @(negedge clock);
        checkOutput("step_lost_lock_pulse_end", int'(lost_lock), 0);

        // Alternating 13/14 ones within tolerance, lock_count=2.
        $display("[TB] alternating code");
        restart(ONES13, 4'd2);
        runWindow();
        checkOutput("alt_we1_locked", int'(locked), 0);
        trim = ONES14;
        runWindow();
        checkOutput("alt_we2_locked", int'(locked), 0);
        trim = ONES13;
        runWindow();
        checkOutput("alt_we3_locked", int'(locked), 1);
        trim = ONES14;
        runWindow();
        checkOutput("alt_we4_locked", int'(locked), 1);
        trim = ONES16;
        runWindow();
        checkOutput("alt_we5_locked", int'(locked), 0);
        checkOutput("alt_we5_lost_lock", int'(lost_lock), 1);
        checkOutput("alt_we5_unlock_count", int'(unlock_count), 2);

        // Rails: code 0 for two windows, recovery, then code 26 for two windows.
        $display("[TB] rail handling");
        restart(ONES13, 4'd1);
        runWindow();
        runWindow();
        checkOutput("rail_prelock", int'(locked), 1);
        trim = 26'h0;
        runWindow();
        checkOutput("rail_w1_state", int'(state), 1);
        checkOutput("rail_w1_lost_lock", int'(lost_lock), 1);
        checkOutput("rail_w1_unlock_count", int'(unlock_count), 3);
        runWindow();
        checkOutput("rail_w2_state", int'(state), 3);
        checkOutput("rail_w2_out_of_range", int'(out_of_range), 1);
        trim = ONES13;
        runWindow();
        checkOutput("rail_recover_state", int'(state), 1);
        checkOutput("rail_recover_out_of_range", int'(out_of_range), 0);
        trim = ONES26;
        runWindow();
        checkOutput("rail26_w1_state", int'(state), 1);
        runWindow();
        checkOutput("rail26_w2_state", int'(state), 3);
        checkOutput("rail26_w2_out_of_range", int'(out_of_range), 1);
        checkOutput("rail26_unlock_count", int'(unlock_count), 3);

        // Disable while locked, then relock with lock_count=0 (acts as 1).
        $display("[TB] disable and zero lock_count");
        restart(ONES13, 4'd3);
        repeat (4) runWindow();
        checkOutput("dis_prelock", int'(locked), 1);
        enable = 1'b0;
        @(negedge clock);
        checkOutput("dis_state", int'(state), 0);
        checkOutput("dis_locked", int'(locked), 0);
        checkOutput("dis_lost_lock", int'(lost_lock), 0);
        checkOutput("dis_unlock_count", int'(unlock_count), 3);
        restart(ONES13, 4'd0);
        runWindow();
        checkOutput("lc0_we1_locked", int'(locked), 0);
        runWindow();
        checkOutput("lc0_we2_locked", int'(locked), 1);

        repeat (3) @(negedge clock);
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
